// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front-end
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small power-of-two FIFO of {instruction, pc} entries with flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    count_q;
    logic           do_push;
    logic           do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];
    assign count   = count_q;

    // Flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - fetch FSM, fetch pointer, credit check and redirect squash
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH      = 2,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        FETCH_CLK,
    input  logic        FETCH_RST_N,
    input  logic        FETCH_REDIRECT,
    input  logic [31:0] FETCH_REDIRECT_ADDR,
    output logic        MEM_REQ,
    output logic [31:0] MEM_ADDR,
    input  logic        MEM_GNT,
    input  logic        MEM_RVALID,
    input  logic [31:0] MEM_RDATA,
    output logic        INSTR_VALID,
    output logic [31:0] INSTR_DATA,
    output logic [31:0] INSTR_PC,
    input  logic        INSTR_READY
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;

    fetch_state_t   state_q;
    fetch_state_t   state_d;
    logic [31:0]    fptr;
    logic [31:0]    pc_q;
    logic [31:0]    redirect_target;
    logic           mem_req_q;
    logic [31:0]    mem_addr_q;
    logic           outstanding_q;
    logic           discard_q;
    logic           credit;
    logic           issue;
    logic           grant;
    logic           resp;
    logic           push;
    logic           pop;
    logic [CW-1:0]  used_slots;
    logic [AW:0]    fifo_count;
    logic           fifo_full;
    logic           fifo_empty;
    fetch_entry_t   push_entry;
    fetch_entry_t   head;
    logic           unused_addr_bits;

    assign redirect_target  = {FETCH_REDIRECT_ADDR[31:2], 2'b00};
    assign unused_addr_bits = ^FETCH_REDIRECT_ADDR[1:0];

    // A slot is reserved for every request in flight, so the FIFO can never overflow.
    assign used_slots = CW'(fifo_count) + CW'(outstanding_q);
    assign credit     = ~fifo_full & (used_slots < CW'(DEPTH));

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        grant   = 1'b0;
        resp    = 1'b0;
        case (state_q)
            IDLE: begin
                if (credit && !FETCH_REDIRECT) begin
                    issue   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (MEM_GNT) begin
                    grant   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (MEM_RVALID) begin
                    resp    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge FETCH_CLK or negedge FETCH_RST_N) begin
        if (!FETCH_RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Once discard is set the pending grant must not advance fptr past the redirect target.
    always_ff @(posedge FETCH_CLK or negedge FETCH_RST_N) begin
        if (!FETCH_RST_N) begin
            mem_req_q     <= 1'b0;
            mem_addr_q    <= RESET_ADDR;
            fptr          <= RESET_ADDR;
            pc_q          <= '0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            if (issue) begin
                mem_req_q  <= 1'b1;
                mem_addr_q <= fptr;
            end else if (grant) begin
                mem_req_q  <= 1'b0;
            end

            if (FETCH_REDIRECT) begin
                fptr <= redirect_target;
            end else if (grant && !discard_q) begin
                fptr <= fptr + 32'(INSTR_BYTES);
            end

            if (grant) begin
                outstanding_q <= 1'b1;
                pc_q          <= mem_addr_q;
            end else if (resp) begin
                outstanding_q <= 1'b0;
            end

            if (resp) begin
                discard_q <= 1'b0;
            end else if (FETCH_REDIRECT && state_q != IDLE) begin
                discard_q <= 1'b1;
            end
        end
    end

    assign push       = resp & ~discard_q & ~FETCH_REDIRECT;
    assign pop        = INSTR_READY & ~fifo_empty & ~FETCH_REDIRECT;
    assign push_entry = {MEM_RDATA, pc_q};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (FETCH_CLK),
        .rst_n      (FETCH_RST_N),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (FETCH_REDIRECT),
        .head       (head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign MEM_REQ     = mem_req_q;
    assign MEM_ADDR    = mem_addr_q;
    assign INSTR_VALID = ~fifo_empty;
    assign INSTR_DATA  = head.instr;
    assign INSTR_PC    = head.pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    logic        rst_n_b = 1'b0;
    logic        redirect_b = 1'b0;
    logic [31:0] redirect_addr_b = '0;
    logic        mem_req_b;
    logic [31:0] mem_addr_b;
    logic        mem_gnt_b = 1'b0;
    logic        mem_rvalid_b = 1'b0;
    logic [31:0] mem_rdata_b = '0;
    logic        instr_valid_b;
    logic [31:0] instr_data_b;
    logic [31:0] instr_pc_b;
    logic        instr_ready_b = 1'b0;

    int errors = 0;
    int checks = 0;

    logic        drv_redirect;
    logic [31:0] drv_raddr;
    logic        drv_ready;
    logic        drv_gnt;
    int          drv_lat;

    logic [31:0] q[$];
    logic [31:0] grant_log[$];
    logic [31:0] pop_log[$];
    logic        pend;
    logic [31:0] pend_addr;
    logic        pend_discard;
    logic        stale_req;
    int          mem_lat;
    logic [31:0] exp_req;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    instr_fetch_queue #(
        .DEPTH      (DEPTH),
        .RESET_ADDR (32'h0000_0000)
    ) dut (
        .FETCH_CLK           (clk),
        .FETCH_RST_N         (rst_n),
        .FETCH_REDIRECT      (redirect),
        .FETCH_REDIRECT_ADDR (redirect_addr),
        .MEM_REQ             (mem_req),
        .MEM_ADDR            (mem_addr),
        .MEM_GNT             (mem_gnt),
        .MEM_RVALID          (mem_rvalid),
        .MEM_RDATA           (mem_rdata),
        .INSTR_VALID         (instr_valid),
        .INSTR_DATA          (instr_data),
        .INSTR_PC            (instr_pc),
        .INSTR_READY         (instr_ready)
    );

    instr_fetch_queue #(
        .DEPTH      (DEPTH),
        .RESET_ADDR (32'hFFFF_FFFC)
    ) dut_b (
        .FETCH_CLK           (clk),
        .FETCH_RST_N         (rst_n_b),
        .FETCH_REDIRECT      (redirect_b),
        .FETCH_REDIRECT_ADDR (redirect_addr_b),
        .MEM_REQ             (mem_req_b),
        .MEM_ADDR            (mem_addr_b),
        .MEM_GNT             (mem_gnt_b),
        .MEM_RVALID          (mem_rvalid_b),
        .MEM_RDATA           (mem_rdata_b),
        .INSTR_VALID         (instr_valid_b),
        .INSTR_DATA          (instr_data_b),
        .INSTR_PC            (instr_pc_b),
        .INSTR_READY         (instr_ready_b)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h0000_0013;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        redirect = 1'b0; redirect_addr = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
        drv_redirect = 1'b0; drv_raddr = '0; drv_ready = 1'b0; drv_gnt = 1'b1; drv_lat = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        q.delete(); grant_log.delete(); pop_log.delete();
        pend = 1'b0; pend_addr = '0; pend_discard = 1'b0; stale_req = 1'b0; mem_lat = 0;
        exp_req = 32'h0; exp_pc = 32'h0;
    endtask

    // One clock: memory responder drives, transaction-level model follows, outputs compared.
    task automatic step();
        logic        s_valid, s_req, d_rv, d_gnt, d_redir, d_ready;
        logic [31:0] s_addr, s_data, s_pc, d_raddr, tgt;
        @(negedge clk);
        s_valid = instr_valid; s_req = mem_req; s_addr = mem_addr;
        s_data = instr_data; s_pc = instr_pc;
        d_rv = pend && (mem_lat == 0);
        d_gnt = s_req && drv_gnt;
        d_redir = drv_redirect; d_raddr = drv_raddr; d_ready = drv_ready;
        tgt = {d_raddr[31:2], 2'b00};
        mem_rvalid = d_rv;
        mem_rdata = d_rv ? word_of(pend_addr) : $urandom();
        mem_gnt = d_gnt;
        redirect = d_redir; redirect_addr = d_raddr; instr_ready = d_ready;
        @(posedge clk);
        #1;
        if (s_valid && d_ready && !d_redir) begin
            pop_log.push_back(s_pc);
            checks++;
            if (s_pc !== exp_pc || s_data !== word_of(s_pc)) begin
                errors++;
                $display("FAIL pop_order got pc=%h data=%h required pc=%h data=%h", s_pc, s_data, exp_pc, word_of(exp_pc));
            end
            exp_pc = s_pc + 32'd4;
            if (q.size() != 0) void'(q.pop_front());
        end
        if (d_redir) begin
            q.delete();
            exp_pc = tgt;
        end
        if (d_rv) begin
            if (!pend_discard && !d_redir) q.push_back(pend_addr);
            pend = 1'b0;
        end
        if (d_gnt) begin
            grant_log.push_back(s_addr);
            pend = 1'b1; pend_addr = s_addr;
            pend_discard = stale_req || d_redir;
            mem_lat = drv_lat - 1;
            if (!stale_req && !d_redir) exp_req = s_addr + 32'd4;
            stale_req = 1'b0;
        end else if (pend && mem_lat != 0) begin
            mem_lat--;
        end
        if (d_redir) begin
            exp_req = tgt;
            if (pend) pend_discard = 1'b1;
            if (s_req && !d_gnt) stale_req = 1'b1;
        end
        checks++;
        if (instr_valid !== (q.size() != 0)) begin
            errors++;
            $display("FAIL instr_valid got=%b required=%b", instr_valid, q.size() != 0);
        end
        if (q.size() != 0) begin
            checks++;
            if (instr_pc !== q[0] || instr_data !== word_of(q[0])) begin
                errors++;
                $display("FAIL head got pc=%h data=%h required pc=%h data=%h", instr_pc, instr_data, q[0], word_of(q[0]));
            end
        end
        if (mem_req && !s_req) begin
            checks++;
            if (mem_addr !== exp_req || pend || q.size() >= DEPTH) begin
                errors++;
                $display("FAIL issue got addr=%h pend=%0b fill=%0d required addr=%h pend=0 fill<%0d", mem_addr, pend, q.size(), exp_req, DEPTH);
            end
        end else if (mem_req && s_req) begin
            checks++;
            if (d_gnt || mem_addr !== s_addr) begin
                errors++;
                $display("FAIL req_hold got addr=%h granted=%0b required addr=%h granted=0", mem_addr, d_gnt, s_addr);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_rvalid = 1'b1; mem_gnt = 1'b1; instr_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || instr_valid !== 1'b0 || instr_data !== 32'h0 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_values got req=%b addr=%h valid=%b data=%h pc=%h required 0 0 0 0 0", mem_req, mem_addr, instr_valid, instr_data, instr_pc);
        end
        checks++;
        if (mem_req_b !== 1'b0 || mem_addr_b !== 32'hFFFF_FFFC || instr_valid_b !== 1'b0 || instr_pc_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_values_b got req=%b addr=%h valid=%b pc=%h required 0 fffffffc 0 0", mem_req_b, mem_addr_b, instr_valid_b, instr_pc_b);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        drv_ready = 1'b1; drv_gnt = 1'b1; drv_lat = 1;
        repeat (30) step();
        checks++;
        if (grant_log.size() != 10) begin
            errors++;
            $display("FAIL b2b_grants got=%0d required=10", grant_log.size());
        end
        checks++;
        if (grant_log.size() < 3 || grant_log[0] !== 32'h0 || grant_log[1] !== 32'h4 || grant_log[2] !== 32'h8) begin
            errors++;
            $display("FAIL b2b_addr_seq got=%p required 0,4,8", grant_log);
        end
        checks++;
        if (pop_log.size() != 9 || pop_log[0] !== 32'h0) begin
            errors++;
            $display("FAIL b2b_pops got count=%0d required count=9 first pc=0", pop_log.size());
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        drv_ready = 1'b0; drv_gnt = 1'b1; drv_lat = 1;
        repeat (20) step();
        checks++;
        if (grant_log.size() != 2 || grant_log[0] !== 32'h0 || grant_log[1] !== 32'h4 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL full_stop got grants=%p req=%b required 0,4 req=0", grant_log, mem_req);
        end
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL full_head got valid=%b pc=%h required valid=1 pc=0", instr_valid, instr_pc);
        end
        drv_ready = 1'b1;
        step();
        drv_ready = 1'b0;
        repeat (10) step();
        checks++;
        if (pop_log.size() != 1 || grant_log.size() != 3 || grant_log[2] !== 32'h8) begin
            errors++;
            $display("FAIL one_pop_refill got pops=%0d grants=%p required pops=1 grants 0,4,8", pop_log.size(), grant_log);
        end
    endtask

    task automatic test_redirect_wait();
        int  n, np;
        logic done;
        apply_reset();
        drv_ready = 1'b1; drv_gnt = 1'b1; drv_lat = 2;
        done = 1'b0; n = 0; np = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (pend && pend_addr == 32'h4 && mem_lat != 0) begin
                drv_redirect = 1'b1; drv_raddr = 32'h0000_1002;
                step();
                drv_redirect = 1'b0;
                n = grant_log.size(); np = pop_log.size();
                done = 1'b1;
            end else begin
                step();
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL redir_wait_timeout got=no WAIT for 0x4 required=WAIT reached");
        end
        repeat (20) step();
        checks++;
        if (grant_log.size() <= n || grant_log[n] !== 32'h0000_1000) begin
            errors++;
            $display("FAIL redir_wait_next_req got=%p required 0x1000 after index %0d", grant_log, n);
        end
        checks++;
        if (pop_log.size() <= np || pop_log[np] !== 32'h0000_1000 || (32'h4 inside {pop_log})) begin
            errors++;
            $display("FAIL redir_wait_pops got=%p required first post-redirect 0x1000, no 0x4", pop_log);
        end
    endtask

    task automatic test_gnt_stall();
        apply_reset();
        drv_ready = 1'b1; drv_gnt = 1'b0; drv_lat = 1;
        for (int i = 0; i < 10 && !mem_req; i++) step();
        for (int i = 0; i < 5; i++) begin
            drv_redirect = (i == 2); drv_raddr = 32'h0000_2001;
            step();
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got req=%b addr=%h required req=1 addr=0", i, mem_req, mem_addr);
            end
        end
        drv_redirect = 1'b0; drv_gnt = 1'b1;
        repeat (15) step();
        checks++;
        if (grant_log.size() < 2 || grant_log[0] !== 32'h0 || grant_log[1] !== 32'h0000_2000) begin
            errors++;
            $display("FAIL stall_grants got=%p required 0,0x2000", grant_log);
        end
        checks++;
        if (pop_log.size() == 0 || pop_log[0] !== 32'h0000_2000) begin
            errors++;
            $display("FAIL stall_first_pop got=%p required first 0x2000", pop_log);
        end
    endtask

    task automatic test_redirect_full();
        int   n;
        logic done;
        apply_reset();
        drv_ready = 1'b0; drv_gnt = 1'b1; drv_lat = 1;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            if (q.size() == 1 && pend && mem_lat == 0) done = 1'b1;
            else step();
        end
        drv_redirect = 1'b1; drv_raddr = 32'h0000_3003; drv_ready = 1'b1;
        step();
        drv_redirect = 1'b0; drv_ready = 1'b0;
        n = grant_log.size();
        checks++;
        if (!done || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_full_valid got reached=%b valid=%b required reached=1 valid=0", done, instr_valid);
        end
        repeat (10) step();
        checks++;
        if (pop_log.size() != 0 || grant_log.size() <= n || grant_log[n] !== 32'h0000_3000) begin
            errors++;
            $display("FAIL redir_full_next got pops=%0d grants=%p required pops=0 next 0x3000", pop_log.size(), grant_log);
        end
        drv_ready = 1'b1;
        repeat (10) step();
        checks++;
        if (pop_log.size() == 0 || pop_log[0] !== 32'h0000_3000) begin
            errors++;
            $display("FAIL redir_full_first_pop got=%p required first 0x3000", pop_log);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            drv_ready = ($urandom_range(3) != 0);
            drv_gnt = ($urandom_range(3) != 0);
            drv_lat = $urandom_range(3, 1);
            drv_redirect = ($urandom_range(19) == 0);
            drv_raddr = ($urandom_range(3) == 0) ? (32'hFFFF_FFF4 | 32'($urandom_range(11))) : $urandom();
            step();
        end
        drv_redirect = 1'b0;
        checks++;
        if (pop_log.size() < 20) begin
            errors++;
            $display("FAIL random_progress got pops=%0d required>=20", pop_log.size());
        end
    endtask

    task automatic test_wrap_reset();
        logic        pb, sreq;
        logic [31:0] pb_addr, saddr;
        logic [31:0] gb[$];
        pb = 1'b0; pb_addr = '0;
        rst_n_b = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sreq = mem_req_b; saddr = mem_addr_b;
            mem_rvalid_b = pb;
            mem_rdata_b = word_of(pb_addr);
            mem_gnt_b = sreq;
            @(posedge clk);
            #1;
            if (mem_rvalid_b) pb = 1'b0;
            if (mem_gnt_b) begin
                gb.push_back(saddr);
                pb = 1'b1; pb_addr = saddr;
            end
        end
        checks++;
        if (gb.size() != 2 || gb[0] !== 32'hFFFF_FFFC || gb[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr_seq got=%p required fffffffc,0", gb);
        end
        checks++;
        if (instr_valid_b !== 1'b1 || instr_pc_b !== 32'hFFFF_FFFC || instr_data_b !== word_of(32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL wrap_head got valid=%b pc=%h data=%h required 1 fffffffc %h", instr_valid_b, instr_pc_b, instr_data_b, word_of(32'hFFFF_FFFC));
        end
        #2 rst_n_b = 1'b0;
        mem_rvalid_b = 1'b0; mem_gnt_b = 1'b0;
        #1;
        checks++;
        if (mem_req_b !== 1'b0 || instr_valid_b !== 1'b0 || mem_addr_b !== 32'hFFFF_FFFC || instr_pc_b !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got req=%b valid=%b addr=%h pc=%h required 0 0 fffffffc 0", mem_req_b, instr_valid_b, mem_addr_b, instr_pc_b);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_redirect_wait();
        test_gnt_stall();
        test_redirect_full();
        test_random();
        test_wrap_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Instruction fetch front-end. It owns the fetch address, issues word reads to instruction memory over a req/gnt/rvalid handshake, and buffers returned instructions in a small FIFO. The FIFO presents {instruction, PC} to decode with valid/ready. A redirect from the PC block (branch, jump or trap target) flushes the FIFO and squashes any in-flight response.

Parameters:
DEPTH, 2, FIFO entries; power of 2, at least 2.
RESET_ADDR, 32'h0000_0000, fetch address after reset.

Ports:
FETCH_CLK  in  1  clock; all state updates on rising edge.
FETCH_RST_N  in  1  reset; asynchronous, active-low.
FETCH_REDIRECT  in  1  one-cycle pulse: restart fetch at FETCH_REDIRECT_ADDR.
FETCH_REDIRECT_ADDR  in  32  new fetch address; bits [1:0] ignored and treated as 0.
MEM_REQ  out  1  read request, registered.
MEM_ADDR  out  32  word-aligned read address, registered.
MEM_GNT  in  1  request accepted this cycle when MEM_REQ=1.
MEM_RVALID  in  1  read data valid; at least 1 cycle after its grant; in order.
MEM_RDATA  in  32  instruction word.
INSTR_VALID  out  1  FIFO head valid.
INSTR_DATA  out  32  head instruction.
INSTR_PC  out  32  head instruction address.
INSTR_READY  in  1  decode consumes head when INSTR_VALID and INSTR_READY are both 1.

Behaviour:
- Reset (FETCH_RST_N=0, asynchronous):
  - MEM_REQ=0, MEM_ADDR=RESET_ADDR, INSTR_VALID=0, INSTR_DATA=0, INSTR_PC=0.
  - FIFO empty; fetch pointer fptr=RESET_ADDR; outstanding=0; discard=0; FSM in IDLE.
  - Reset mid-transaction abandons everything. Memory must drop any pending rvalid on reset.
- One outstanding request max.
- Credit rule: a request is issued only if count + outstanding < DEPTH. Every granted response therefore has a reserved slot, and overflow is impossible.
- FSM states:
  - IDLE: if credit is available and there is no redirect, set MEM_REQ=1 and MEM_ADDR=fptr next cycle, then go to REQ.
  - REQ: hold MEM_REQ and MEM_ADDR stable until MEM_GNT. On grant: MEM_REQ=0, fptr+=4, outstanding=1, go to WAIT. The request is never withdrawn, even on redirect.
  - WAIT: on MEM_RVALID, if discard=0 push {MEM_RDATA, address} into the FIFO; clear outstanding and discard; go to IDLE.
- Back-to-back issue: when IDLE is re-entered with credit, the next request starts the following cycle. Steady-state throughput is 1 instruction per 3 cycles with 1-cycle memory latency.
- The FIFO stores the PC of each request, captured at grant. INSTR_PC is the address of INSTR_DATA. fptr wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Redirect cycle:
  - FIFO cleared (count=0). A same-cycle pop is ignored.
  - fptr = {FETCH_REDIRECT_ADDR[31:2], 2'b00}.
  - If in REQ or WAIT, set discard=1. The pending request completes normally and its data is dropped.
  - If in IDLE, no issue occurs that cycle. Issue from the new fptr starts next cycle.
  - Redirect coincident with MEM_GNT: fptr still takes the redirect address (no +4), and discard=1.
  - Redirect coincident with MEM_RVALID: that data is dropped.
  - INSTR_VALID=0 the cycle after a redirect.
- Push and pop in the same cycle: count unchanged, data order preserved.
- Full (count=DEPTH): no issue. Empty: INSTR_VALID=0.
- A new redirect while discard=1 only updates fptr.
- Outputs are registered. There is no combinational path from MEM_* inputs to INSTR_* outputs, or from INSTR_READY to MEM_*.

Decomposition:
- Package fetch_pkg:
  - enum fetch_state_t {IDLE, REQ, WAIT}.
  - typedef fetch_entry_t struct {logic [31:0] instr; logic [31:0] pc}.
  - localparam INSTR_BYTES=4.
- Sub-module fetch_fifo (DEPTH, fetch_entry_t): push, pop, flush, count, full, empty.
- instr_fetch_queue holds the FSM, fptr, the credit logic and the discard flag.

Test Plan:
1. Reset release; memory grants immediately, rvalid 1 cycle later with data 32'h0000_0013; READY=1 -> MEM_ADDR sequence 0x0, 0x4, 0x8. INSTR_PC=0x0 with INSTR_DATA=0x13 is seen first. Reset values are checked while RST_N=0.
2. INSTR_READY=0 held -> exactly 2 requests (0x0, 0x4), then MEM_REQ stays 0 with count=2. Raising READY for 1 cycle -> one pop, then one new request to 0x8.
3. Redirect to 0x0000_1002 while in WAIT for 0x4 -> the 0x4 data is dropped and never visible. The next MEM_ADDR is 0x1000, and the first INSTR_PC after that is 0x1000.
4. MEM_GNT withheld 5 cycles -> MEM_REQ/MEM_ADDR stay stable. Redirect during the stall -> the old address is still granted, its response is discarded, and the next request goes to the redirect target.
5. Redirect coincident with MEM_RVALID and INSTR_READY while FIFO is full -> FIFO empty, INSTR_VALID=0 next cycle, no stale entry ever presented.
6. RESET_ADDR=32'hFFFF_FFFC -> MEM_ADDR sequence 0xFFFF_FFFC, 0x0000_0000. Asserting RST_N=0 mid-WAIT -> MEM_REQ=0 and INSTR_VALID=0 immediately, without a clock edge.
